det_engine: RTL and testbench

DET_ENGINE -- requirements
Module: det_engine

---
 rtl/det_pkg.sv | 25 ++
 rtl/det_if.sv | 29 ++
 rtl/det_mac.sv | 44 ++++
 rtl/det_engine.sv | 157 +++++++++++++++
 tb/tb_det_engine.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : det_pkg
// Purpose  : Shared types and constants for the determinant engine.
// Revision : 1.0
// ============================================================================
package det_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic       MODE_2X2  = 1'b0;
    localparam logic       MODE_3X3  = 1'b1;
    localparam logic [3:0] STEPS_2X2 = 4'd2;
    localparam logic [3:0] STEPS_3X3 = 4'd9;

    function automatic logic [3:0] last_step(input logic mode);
        return (mode == MODE_3X3) ? (STEPS_3X3 - 4'd1) : (STEPS_2X2 - 4'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/det_if.sv
`default_nettype none
// ============================================================================
// Module   : det_if
// Purpose  : Request/result handshake bundle of the determinant engine.
// Revision : 1.0
// ============================================================================
interface det_if #(
    parameter int DW = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic            mode;
    logic [9*DW-1:0] m_flat;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   det;
    logic            ovf;

    modport master (
        output in_valid, mode, m_flat, out_ready,
        input  in_ready, out_valid, det, ovf
    );

    modport slave (
        input  in_valid, mode, m_flat, out_ready,
        output in_ready, out_valid, det, ovf
    );
endinterface
`default_nettype wire

// File: rtl/det_mac.sv
`default_nettype none
// ============================================================================
// Module   : det_mac
// Purpose  : Signed multiply with add/subtract accumulate, sync clear.
// Revision : 1.0
// ============================================================================
module det_mac #(
    parameter int DW   = 32,
    parameter int ACCW = 2*DW+4
) (
    input  wire                    clk,
    input  wire                    reset,
    input  wire                    clr_i,
    input  wire                    en_i,
    input  wire                    load_i,
    input  wire                    sub_i,
    input  wire signed [DW-1:0]    a_i,
    input  wire signed [ACCW-1:0]  b_i,
    output logic signed [ACCW-1:0] acc_d_o
);

    logic signed [ACCW-1:0] acc_q;
    logic signed [ACCW-1:0] w_a_ext;
    logic signed [ACCW-1:0] w_term;
    logic signed [ACCW-1:0] w_base;

    // Product kept modulo 2^ACCW; the final result is only defined to that width.
    assign w_a_ext = ACCW'(a_i);
    assign w_term  = w_a_ext * b_i;
    assign w_base  = load_i ? '0 : acc_q;
    assign acc_d_o = sub_i ? (w_base - w_term) : (w_base + w_term);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/det_engine.sv
`default_nettype none
// ============================================================================
// Module   : det_engine
// Purpose  : Sequential 2x2 / 3x3 signed determinant, one multiply per cycle.
// Revision : 1.0
// ============================================================================
module det_engine
    import det_pkg::*;
#(
    parameter int DW   = 32,
    parameter int ACCW = 2*DW+4
) (
    input wire  clk,
    input wire  reset,
    det_if.slave bus
);

    state_t                 state_q;
    logic [9*DW-1:0]        m_q;
    logic                   mode_q;
    logic [3:0]             step_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   ovf_q;
    logic [DW-1:0]          det_q;
    logic signed [ACCW-1:0] minor0_q;
    logic signed [ACCW-1:0] minor1_q;
    logic signed [ACCW-1:0] minor2_q;

    logic signed [DW-1:0]   w_m [9];
    logic signed [DW-1:0]   w_op_a;
    logic signed [ACCW-1:0] w_op_b;
    logic                   w_op_sub;
    logic                   w_op_load;
    logic signed [ACCW-1:0] w_acc_d;
    logic [ACCW-DW:0]       w_upper;
    logic                   w_ovf;
    logic                   w_accept;
    logic                   w_last;

    function automatic logic signed [ACCW-1:0] sx(input logic signed [DW-1:0] v);
        return ACCW'(v);
    endfunction

    for (genvar k = 0; k < 9; k++) begin : g_elem
        assign w_m[k] = m_q[k*DW +: DW];
    end

    assign w_accept = (state_q == S_IDLE) && in_ready_q && bus.in_valid;
    assign w_last   = (step_q == last_step(mode_q));

    // Steps 0-5 of 3x3 build the minors, each restarting the accumulator;
    // steps 6-8 fold them in with the first-row cofactor signs.
    always_comb begin
        w_op_a    = '0;
        w_op_b    = '0;
        w_op_sub  = 1'b0;
        w_op_load = 1'b0;
        if (mode_q == MODE_2X2) begin
            if (step_q == 4'd0) begin
                w_op_a = w_m[0]; w_op_b = sx(w_m[4]); w_op_load = 1'b1;
            end else begin
                w_op_a = w_m[1]; w_op_b = sx(w_m[3]); w_op_sub = 1'b1;
            end
        end else begin
            case (step_q)
                4'd0: begin w_op_a = w_m[4]; w_op_b = sx(w_m[8]); w_op_load = 1'b1; end
                4'd1: begin w_op_a = w_m[5]; w_op_b = sx(w_m[7]); w_op_sub  = 1'b1; end
                4'd2: begin w_op_a = w_m[3]; w_op_b = sx(w_m[8]); w_op_load = 1'b1; end
                4'd3: begin w_op_a = w_m[5]; w_op_b = sx(w_m[6]); w_op_sub  = 1'b1; end
                4'd4: begin w_op_a = w_m[3]; w_op_b = sx(w_m[7]); w_op_load = 1'b1; end
                4'd5: begin w_op_a = w_m[4]; w_op_b = sx(w_m[6]); w_op_sub  = 1'b1; end
                4'd6: begin w_op_a = w_m[0]; w_op_b = minor0_q;   w_op_load = 1'b1; end
                4'd7: begin w_op_a = w_m[1]; w_op_b = minor1_q;   w_op_sub  = 1'b1; end
                default: begin w_op_a = w_m[2]; w_op_b = minor2_q; end
            endcase
        end
    end

    det_mac #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (w_accept),
        .en_i    (state_q == S_MUL),
        .load_i  (w_op_load),
        .sub_i   (w_op_sub),
        .a_i     (w_op_a),
        .b_i     (w_op_b),
        .acc_d_o (w_acc_d)
    );

    // Fits in signed DW exactly when every bit from DW-1 upward matches the sign.
    assign w_upper = w_acc_d[ACCW-1:DW-1];
    assign w_ovf   = !((&w_upper) || !(|w_upper));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            m_q         <= '0;
            mode_q      <= MODE_2X2;
            step_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            det_q       <= '0;
            minor0_q    <= '0;
            minor1_q    <= '0;
            minor2_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        m_q        <= bus.m_flat;
                        mode_q     <= bus.mode;
                        step_q     <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_MUL;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                S_MUL: begin
                    step_q <= step_q + 4'd1;
                    if (mode_q == MODE_3X3) begin
                        if (step_q == 4'd1) minor0_q <= w_acc_d;
                        if (step_q == 4'd3) minor1_q <= w_acc_d;
                        if (step_q == 4'd5) minor2_q <= w_acc_d;
                    end
                    if (w_last) begin
                        det_q       <= w_acc_d[DW-1:0];
                        ovf_q       <= w_ovf;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.det       = det_q;
    assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_det_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_det_engine
// Purpose  : Self-checking bench for det_engine at DW=32 and DW=8.
// Revision : 1.0
// ============================================================================
module tb_det_engine;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    det_if #(.DW(32)) b32 ();
    det_if #(.DW(8))  b8 ();

    det_engine #(.DW(32)) u32 (.clk(clk), .reset(rst_n), .bus(b32.slave));
    det_engine #(.DW(8))  u8  (.clk(clk), .reset(rst_n), .bus(b8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Exact determinant, wrapped to ACCW, then truncated to DW.
    function automatic void model(input longint m[9], input bit mode, input int dw,
                                  output longint det, output bit ovf);
        logic signed [127:0] x [9];
        logic signed [127:0] e;
        logic signed [127:0] acc;
        logic signed [127:0] lim;
        logic signed [127:0] d;
        int accw;
        accw = 2*dw + 4;
        for (int i = 0; i < 9; i++) x[i] = 128'(m[i]);
        if (!mode) e = x[0]*x[4] - x[1]*x[3];
        else       e = x[0]*(x[4]*x[8] - x[5]*x[7])
                     - x[1]*(x[3]*x[8] - x[5]*x[6])
                     + x[2]*(x[3]*x[7] - x[4]*x[6]);
        acc = e <<< (128 - accw);
        acc = acc >>> (128 - accw);
        lim = 128'sd1 <<< (dw - 1);
        ovf = (acc < -lim) || (acc > lim - 128'sd1);
        d   = acc <<< (128 - dw);
        d   = d >>> (128 - dw);
        det = longint'(d);
    endfunction

    function automatic longint rd_det(input bit w8);
        return w8 ? longint'($signed(b8.det)) : longint'($signed(b32.det));
    endfunction
    function automatic longint rd_ov(input bit w8);
        return w8 ? longint'(b8.out_valid) : longint'(b32.out_valid);
    endfunction
    function automatic longint rd_ovf(input bit w8);
        return w8 ? longint'(b8.ovf) : longint'(b32.ovf);
    endfunction
    function automatic longint rd_ir(input bit w8);
        return w8 ? longint'(b8.in_ready) : longint'(b32.in_ready);
    endfunction

    task automatic set_req(input bit w8, input bit v, input longint m[9], input bit mode);
        if (w8) begin
            b8.in_valid = v; b8.mode = mode;
            for (int i = 0; i < 9; i++) b8.m_flat[i*8 +: 8] = m[i][7:0];
        end else begin
            b32.in_valid = v; b32.mode = mode;
            for (int i = 0; i < 9; i++) b32.m_flat[i*32 +: 32] = m[i][31:0];
        end
    endtask

    task automatic set_junk(input bit w8, input bit v);
        longint j [9];
        for (int i = 0; i < 9; i++) j[i] = longint'($signed($urandom));
        set_req(w8, v, j, 1'($urandom));
    endtask

    task automatic set_ordy(input bit w8, input bit r);
        if (w8) b8.out_ready = r; else b32.out_ready = r;
    endtask

    task automatic txn(input bit w8, input longint m[9], input bit mode,
                       input int hold, input string tag);
        longint edet;
        bit     eovf;
        int     lat;
        model(m, mode, w8 ? 8 : 32, edet, eovf);
        check({tag, ".in_ready"}, rd_ir(w8), 1);
        set_req(w8, 1'b1, m, mode);
        @(posedge clk); #1;
        set_junk(w8, 1'b0);
        set_ordy(w8, hold == 0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (rd_ov(w8) == 0 && lat < 30);
        check({tag, ".out_valid"}, rd_ov(w8), 1);
        check({tag, ".latency"}, longint'(lat), mode ? 9 : 2);
        check({tag, ".det"}, rd_det(w8), edet);
        check({tag, ".ovf"}, rd_ovf(w8), longint'(eovf));
        for (int i = 0; i < hold; i++) begin
            set_junk(w8, 1'b1);
            @(posedge clk); #1;
            check({tag, ".hold_det"}, rd_det(w8), edet);
            check({tag, ".hold_ovf"}, rd_ovf(w8), longint'(eovf));
            check({tag, ".hold_valid"}, rd_ov(w8), 1);
            check({tag, ".hold_in_ready"}, rd_ir(w8), 0);
        end
        if (hold > 0) begin
            set_junk(w8, 1'b0);
            set_ordy(w8, 1'b1);
        end
        @(posedge clk); #1;
        set_ordy(w8, 1'b0);
        check({tag, ".drained"}, rd_ov(w8), 0);
        check({tag, ".idle_ready"}, rd_ir(w8), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint m [9];
        bit     w8;
        bit     mode;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        set_junk(1'b0, 1'b0); set_ordy(1'b0, 1'b0);
        set_junk(1'b1, 1'b0); set_ordy(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst.out_valid", rd_ov(k[0]), 0);
            check("rst.det", rd_det(k[0]), 0);
            check("rst.ovf", rd_ovf(k[0]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst.in_ready32", rd_ir(1'b0), 1);
        check("rst.in_ready8", rd_ir(1'b1), 1);

        m = '{3, 8, 7, 4, 6, 9, -5, 11, 2};
        txn(1'b0, m, 1'b0, 1, "d2x2");
        m = '{6, 1, 1, 4, -2, 5, 2, 8, 7};
        txn(1'b0, m, 1'b1, 0, "d3x3");
        m = '{100, 0, 0, 0, 100, 0, 0, 0, 0};
        txn(1'b1, m, 1'b0, 0, "ovf8");
        m = '{-7, 3, 12, 5, 9, -4, 1, 2, 3};
        txn(1'b0, m, 1'b1, 5, "bp_first");
        m = '{2, -9, 0, 13, 4, 0, 0, 0, 0};
        txn(1'b0, m, 1'b0, 0, "bp_second");

        // Abort during the fourth multiply of a 3x3 operation.
        m = '{1, 2, 3, 4, 5, 6, 7, 8, 10};
        set_req(1'b0, 1'b1, m, 1'b1);
        @(posedge clk); #1;
        set_junk(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.out_valid", rd_ov(1'b0), 0);
        check("abort.det", rd_det(1'b0), 0);
        check("abort.ovf", rd_ovf(1'b0), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort.in_ready", rd_ir(1'b0), 1);
        repeat (10) @(posedge clk);
        #1;
        check("abort.no_result", rd_ov(1'b0), 0);
        m = '{3, 8, 0, 4, 6, 0, 0, 0, 0};
        txn(1'b0, m, 1'b0, 0, "after_abort");

        for (int i = 0; i < 30; i++) begin
            w8   = (i % 3 == 0);
            mode = 1'($urandom);
            for (int k = 0; k < 9; k++) begin
                if (w8)          m[k] = longint'($signed(8'($urandom)));
                else if (i % 2 == 1) m[k] = longint'($urandom_range(200)) - 100;
                else             m[k] = longint'($signed($urandom));
            end
            txn(w8, m, mode, int'($urandom_range(3)), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
